// File: rtl/mem_port_arbiter.sv
// Arbitrates one byte-wide synchronous memory between instruction fetch and data access,
// serialising 32-bit requests into per-lane byte transfers and assembling read words.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter bit ME_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_done_o,
  output logic              if_stall_req_o,
  input  logic              me_req_i,
  input  logic              me_we_i,
  input  logic [ADDR_W-1:0] me_addr_i,
  input  logic [3:0]        me_sel_i,
  input  logic [31:0]       me_wdata_i,
  output logic [31:0]       me_rdata_o,
  output logic              me_done_o,
  output logic              me_stall_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  input  logic [7:0]        mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              own_me_q, own_me_d;
  logic [ADDR_W-1:2] base_q, base_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        lane_q, lane_d;
  logic              cap_vld_q, cap_vld_d;
  logic [1:0]        cap_lane_q, cap_lane_d;
  logic [31:0]       word_q, word_d;
  logic              if_done_q, if_done_d;
  logic              me_done_q, me_done_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       me_rdata_q, me_rdata_d;

  logic        if_go, grant_me, grant_any, abort, xfer;
  logic [3:0]  req_sel;
  logic [2:0]  first_lane, next_lane;
  logic [31:0] word_merged;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{if_addr_i[1:0], me_addr_i[1:0]};

  // Lowest selected lane at or above 'from'; bit 2 set means no lane remains.
  function automatic logic [2:0] find_lane(input logic [3:0] sel, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (sel[i] && (3'(i) >= from)) res = {1'b0, 2'(i)};
    end
    return res;
  endfunction

  assign if_go      = if_req_i & ~if_flush_i;
  assign grant_me   = ME_PRIORITY ? me_req_i : (me_req_i & ~if_go);
  assign grant_any  = me_req_i | if_go;
  assign req_sel    = grant_me ? me_sel_i : 4'hF;
  assign first_lane = find_lane(req_sel, 3'd0);
  assign next_lane  = find_lane(sel_q, {1'b0, lane_q} + 3'd1);
  assign abort      = ~own_me_q & if_flush_i;

  // The byte issued last cycle arrives now; fold it into its lane slot.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign word_merged[8*gi +: 8] = (cap_vld_q && (cap_lane_q == 2'(gi))) ?
                                      mem_rdata_i : word_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    own_me_d   = own_me_q;
    base_d     = base_q;
    sel_d      = sel_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    lane_d     = lane_q;
    cap_vld_d  = 1'b0;
    cap_lane_d = lane_q;
    word_d     = word_merged;
    if_done_d  = 1'b0;
    me_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    me_rdata_d = me_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          own_me_d = grant_me;
          base_d   = grant_me ? me_addr_i[ADDR_W-1:2] : if_addr_i[ADDR_W-1:2];
          sel_d    = req_sel;
          we_d     = grant_me & me_we_i;
          wdata_d  = grant_me ? me_wdata_i : 32'h0;
          word_d   = 32'h0;
          if (first_lane[2]) begin
            state_d    = S_DONE;
            me_done_d  = 1'b1;
            me_rdata_d = 32'h0;
          end else begin
            state_d = S_XFER;
            lane_d  = first_lane[1:0];
          end
        end
      end
      S_XFER: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cap_vld_d = ~we_q;
          if (!next_lane[2]) begin
            lane_d = next_lane[1:0];
          end else if (!we_q) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_DONE;
            if (own_me_q) begin
              me_done_d  = 1'b1;
              me_rdata_d = word_merged;
            end else begin
              if_done_d  = 1'b1;
              if_rdata_d = word_merged;
            end
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          if (own_me_q) begin
            me_done_d  = 1'b1;
            me_rdata_d = word_merged;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = word_merged;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      own_me_q   <= 1'b0;
      base_q     <= '0;
      sel_q      <= 4'h0;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      lane_q     <= 2'd0;
      cap_vld_q  <= 1'b0;
      cap_lane_q <= 2'd0;
      word_q     <= 32'h0;
      if_done_q  <= 1'b0;
      me_done_q  <= 1'b0;
      if_rdata_q <= 32'h0;
      me_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      own_me_q   <= own_me_d;
      base_q     <= base_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      lane_q     <= lane_d;
      cap_vld_q  <= cap_vld_d;
      cap_lane_q <= cap_lane_d;
      word_q     <= word_d;
      if_done_q  <= if_done_d;
      me_done_q  <= me_done_d;
      if_rdata_q <= if_rdata_d;
      me_rdata_q <= me_rdata_d;
    end
  end

  assign xfer           = (state_q == S_XFER);
  assign mem_addr_o     = xfer ? {base_q, lane_q} : '0;
  assign mem_we_o       = xfer & we_q;
  assign mem_wdata_o    = xfer ? wdata_q[8*lane_q +: 8] : 8'h00;
  assign if_done_o      = if_done_q;
  assign me_done_o      = me_done_q;
  assign if_rdata_o     = if_rdata_q;
  assign me_rdata_o     = me_rdata_q;
  assign if_stall_req_o = if_req_i & ~if_done_q & ~if_flush_i;
  assign me_stall_req_o = me_req_i & ~me_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: byte-serial IF/ME transfers against a small memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = 32'h0;
  logic        if_flush_i = 1'b0;
  logic [31:0] if_rdata_o;
  logic        if_done_o;
  logic        if_stall_req_o;
  logic        me_req_i = 1'b0;
  logic        me_we_i = 1'b0;
  logic [31:0] me_addr_i = 32'h0;
  logic [3:0]  me_sel_i = 4'h0;
  logic [31:0] me_wdata_i = 32'h0;
  logic [31:0] me_rdata_o;
  logic        me_done_o;
  logic        me_stall_req_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_we_o;
  logic [7:0]  mem_rdata_i = 8'h00;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .ME_PRIORITY(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rdata_o(if_rdata_o), .if_done_o(if_done_o), .if_stall_req_o(if_stall_req_o),
    .me_req_i(me_req_i), .me_we_i(me_we_i), .me_addr_i(me_addr_i), .me_sel_i(me_sel_i),
    .me_wdata_i(me_wdata_i), .me_rdata_o(me_rdata_o), .me_done_o(me_done_o),
    .me_stall_req_o(me_stall_req_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_rdata_i(mem_rdata_i)
  );

  // Synchronous byte memory: read data valid the cycle after the address.
  always @(posedge clk) begin
    if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
    mem_rdata_i <= mem.exists(mem_addr_o) ? mem[mem_addr_o] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    mem[32'h100]  = 8'h13; mem[32'h101]  = 8'h05;
    mem[32'h102]  = 8'h00; mem[32'h103]  = 8'h00;
    mem[32'h2002] = 8'h34; mem[32'h2003] = 8'h12;

    // Reset
    wait_cycle(); wait_cycle();
    chk("rst_if_done", {31'h0, if_done_o}, 32'h0);
    chk("rst_me_done", {31'h0, me_done_o}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_if_rdata", if_rdata_o, 32'h0);
    chk("rst_me_rdata", me_rdata_o, 32'h0);
    rst = 1'b0;
    $display("txn reset");

    // IF word read at 0x100
    wait_cycle();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    #1;
    chk("if1_g_stall", {31'h0, if_stall_req_o}, 32'h1);
    chk("if1_g_addr", mem_addr_o, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      wait_cycle();
      chk($sformatf("if1_addr_k%0d", k), mem_addr_o, (k <= 4) ? 32'h100 + 32'(k - 1) : 32'h0);
      chk($sformatf("if1_done_k%0d", k), {31'h0, if_done_o}, {31'h0, k == 6});
    end
    chk("if1_rdata", if_rdata_o, 32'h00000513);
    if_req_i = 1'b0;
    $display("txn if_read 0x100");

    // ME single-byte write at 0x1002
    wait_cycle();
    me_req_i = 1'b1; me_we_i = 1'b1; me_addr_i = 32'h1002; me_sel_i = 4'b0100;
    me_wdata_i = 32'h00AB0000;
    wait_cycle();
    chk("mew_we", {31'h0, mem_we_o}, 32'h1);
    chk("mew_addr", mem_addr_o, 32'h1002);
    chk("mew_wdata", {24'h0, mem_wdata_o}, 32'hAB);
    chk("mew_done_k1", {31'h0, me_done_o}, 32'h0);
    wait_cycle();
    chk("mew_done_k2", {31'h0, me_done_o}, 32'h1);
    chk("mew_we_k2", {31'h0, mem_we_o}, 32'h0);
    chk("mew_mem", {24'h0, mem[32'h1002]}, 32'hAB);
    me_req_i = 1'b0;
    $display("txn me_write 0x1002");

    // ME two-byte read at 0x2002
    wait_cycle();
    me_req_i = 1'b1; me_we_i = 1'b0; me_addr_i = 32'h2002; me_sel_i = 4'b1100;
    wait_cycle();
    chk("mer_addr_k1", mem_addr_o, 32'h2002);
    chk("mer_we_k1", {31'h0, mem_we_o}, 32'h0);
    wait_cycle();
    chk("mer_addr_k2", mem_addr_o, 32'h2003);
    wait_cycle();
    chk("mer_addr_k3", mem_addr_o, 32'h0);
    chk("mer_done_k3", {31'h0, me_done_o}, 32'h0);
    wait_cycle();
    chk("mer_done_k4", {31'h0, me_done_o}, 32'h1);
    chk("mer_rdata", me_rdata_o, 32'h12340000);
    me_req_i = 1'b0;
    $display("txn me_read 0x2002");

    // ME with no lanes selected
    wait_cycle();
    me_req_i = 1'b1; me_we_i = 1'b0; me_addr_i = 32'h2000; me_sel_i = 4'b0000;
    wait_cycle();
    chk("mez_done", {31'h0, me_done_o}, 32'h1);
    chk("mez_rdata", me_rdata_o, 32'h0);
    chk("mez_addr", mem_addr_o, 32'h0);
    me_req_i = 1'b0;
    $display("txn me_sel_zero");

    // Simultaneous IF and ME: ME first, IF after
    wait_cycle();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    me_req_i = 1'b1; me_we_i = 1'b0; me_addr_i = 32'h2002; me_sel_i = 4'b1100;
    for (int k = 1; k <= 11; k++) begin
      wait_cycle();
      chk($sformatf("arb_if_stall_k%0d", k), {31'h0, if_stall_req_o}, {31'h0, k < 11});
      chk($sformatf("arb_me_done_k%0d", k), {31'h0, me_done_o}, {31'h0, k == 4});
      chk($sformatf("arb_if_done_k%0d", k), {31'h0, if_done_o}, {31'h0, k == 11});
      if (k == 1) chk("arb_addr_k1", mem_addr_o, 32'h2002);
      if (k == 5) chk("arb_addr_k5", mem_addr_o, 32'h0);
      if (k == 6) chk("arb_addr_k6", mem_addr_o, 32'h100);
      if (k == 9) chk("arb_addr_k9", mem_addr_o, 32'h103);
      if (k == 4) begin
        chk("arb_me_rdata", me_rdata_o, 32'h12340000);
        me_req_i = 1'b0;
      end
    end
    chk("arb_if_rdata", if_rdata_o, 32'h00000513);
    if_req_i = 1'b0;
    $display("txn arb_me_then_if");

    // IF read flushed at G+2 with ME pending
    wait_cycle();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    wait_cycle();
    chk("fl_addr_k1", mem_addr_o, 32'h100);
    me_req_i = 1'b1; me_we_i = 1'b0; me_addr_i = 32'h2002; me_sel_i = 4'b1100;
    wait_cycle();
    chk("fl_addr_k2", mem_addr_o, 32'h101);
    if_flush_i = 1'b1;
    #1;
    chk("fl_stall_k2", {31'h0, if_stall_req_o}, 32'h0);
    for (int k = 3; k <= 7; k++) begin
      wait_cycle();
      if (k == 3) begin
        if_flush_i = 1'b0; if_req_i = 1'b0;
        chk("fl_addr_k3", mem_addr_o, 32'h0);
      end
      chk($sformatf("fl_if_done_k%0d", k), {31'h0, if_done_o}, 32'h0);
      if (k == 4) chk("fl_addr_k4", mem_addr_o, 32'h2002);
      chk($sformatf("fl_me_done_k%0d", k), {31'h0, me_done_o}, {31'h0, k == 7});
    end
    chk("fl_me_rdata", me_rdata_o, 32'h12340000);
    me_req_i = 1'b0;
    $display("txn if_flush_me_pending");

    // Reset in the middle of an ME word write, then restart
    wait_cycle();
    me_req_i = 1'b1; me_we_i = 1'b1; me_addr_i = 32'h3000; me_sel_i = 4'b1111;
    me_wdata_i = 32'hDDCCBBAA;
    wait_cycle();
    chk("rw_we_k1", {31'h0, mem_we_o}, 32'h1);
    chk("rw_wdata_k1", {24'h0, mem_wdata_o}, 32'hAA);
    wait_cycle();
    rst = 1'b1;
    wait_cycle();
    chk("rw_we_k3", {31'h0, mem_we_o}, 32'h0);
    chk("rw_done_k3", {31'h0, me_done_o}, 32'h0);
    chk("rw_if_rdata_k3", if_rdata_o, 32'h0);
    chk("rw_me_rdata_k3", me_rdata_o, 32'h0);
    rst = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      wait_cycle();
      chk($sformatf("rw_we_k%0d", k), {31'h0, mem_we_o}, {31'h0, k <= 7});
      if (k <= 7) chk($sformatf("rw_addr_k%0d", k), mem_addr_o, 32'h3000 + 32'(k - 4));
      chk($sformatf("rw_done_k%0d", k), {31'h0, me_done_o}, {31'h0, k == 8});
    end
    chk("rw_wdata_mem", {mem[32'h3003], mem[32'h3002], mem[32'h3001], mem[32'h3000]}, 32'hDDCCBBAA);
    me_req_i = 1'b0;
    $display("txn reset_mid_write");

    wait_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
